// File: rtl/roce_stack_xlat_arbiter.sv
// Round-robin arbiter sharing one translation-table port among NUM_REQ handlers,
// one lookup in flight, with a watchdog that turns a lost response into an error reply.
module roce_stack_xlat_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  aresetn_i,
    input  logic [NUM_REQ-1:0]    s_req_valid_i,
    output logic [NUM_REQ-1:0]    s_req_ready_o,
    input  logic [64*NUM_REQ-1:0] s_req_vaddr_i,
    output logic [NUM_REQ-1:0]    s_resp_valid_o,
    input  logic [NUM_REQ-1:0]    s_resp_ready_i,
    output logic [115:0]          s_resp_data_o,
    output logic                  m_req_valid_o,
    input  logic                  m_req_ready_i,
    output logic [63:0]           m_req_vaddr_o,
    input  logic                  m_resp_valid_i,
    output logic                  m_resp_ready_o,
    input  logic [115:0]          m_resp_data_i,
    output logic [2:0]            grant_id_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        RQ_IDLE,
        RQ_ISSUE,
        RQ_WAIT,
        RQ_DELIVER
    } rq_state_t;

    rq_state_t      r_state;
    rq_state_t      w_state_nxt;
    logic [2:0]     r_last_grant;
    logic [2:0]     r_grant_id;
    logic [63:0]    r_vaddr;
    logic [115:0]   r_resp_data;
    logic [31:0]    r_timer;
    logic [3:0]     r_stale_cnt;
    logic           r_timeout;

    logic           w_hi_found;
    logic           w_lo_found;
    logic [2:0]     w_hi_idx;
    logic [2:0]     w_lo_idx;
    logic [2:0]     w_gnt;
    logic           w_any;
    logic [63:0]    w_gnt_vaddr;
    logic           w_resp_hit;
    logic           w_fire;
    logic           w_stale_drop;
    logic           w_deliver_done;

    // Round-robin: lowest valid index above last_grant, else lowest valid index overall.
    always_comb begin
        w_hi_found  = 1'b0;
        w_lo_found  = 1'b0;
        w_hi_idx    = '0;
        w_lo_idx    = '0;
        w_gnt_vaddr = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (s_req_valid_i[j]) begin
                if (!w_hi_found && (j > 32'(r_last_grant))) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = 3'(j);
                end
                if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = 3'(j);
                end
            end
        end
        w_gnt = w_hi_found ? w_hi_idx : w_lo_idx;
        // Gating with reset keeps ready low while the block is held in reset.
        w_any = w_lo_found & aresetn_i;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (3'(j) == w_gnt) w_gnt_vaddr = s_req_vaddr_i[64*j +: 64];
        end
    end

    assign w_resp_hit   = (r_state == RQ_WAIT) && m_resp_valid_i && (r_stale_cnt == 4'd0);
    assign w_fire       = (TIMEOUT_CYCLES != 0) && (r_state == RQ_WAIT) && !w_resp_hit
                          && (r_timer == TIMEOUT_CYCLES - 1);
    assign w_stale_drop = m_resp_valid_i && m_resp_ready_o && (r_stale_cnt != 4'd0);

    always_comb begin
        w_state_nxt    = r_state;
        s_req_ready_o  = '0;
        s_resp_valid_o = '0;
        m_req_valid_o  = 1'b0;
        m_resp_ready_o = (r_stale_cnt != 4'd0);
        w_deliver_done = 1'b0;
        case (r_state)
            RQ_IDLE: begin
                if (w_any) begin
                    for (int unsigned j = 0; j < NUM_REQ; j++) begin
                        s_req_ready_o[j] = (3'(j) == w_gnt);
                    end
                    w_state_nxt = RQ_ISSUE;
                end
            end
            RQ_ISSUE: begin
                m_req_valid_o = 1'b1;
                if (m_req_ready_i) w_state_nxt = RQ_WAIT;
            end
            RQ_WAIT: begin
                m_resp_ready_o = 1'b1;
                if (w_resp_hit || w_fire) w_state_nxt = RQ_DELIVER;
            end
            RQ_DELIVER: begin
                m_resp_ready_o = 1'b0;
                for (int unsigned j = 0; j < NUM_REQ; j++) begin
                    s_resp_valid_o[j] = (3'(j) == r_grant_id);
                end
                w_deliver_done = |(s_resp_valid_o & s_resp_ready_i);
                if (w_deliver_done) w_state_nxt = RQ_IDLE;
            end
            default: w_state_nxt = RQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) r_state <= RQ_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_last_grant <= 3'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_vaddr      <= '0;
            r_resp_data  <= '0;
            r_timer      <= '0;
            r_stale_cnt  <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= w_fire;
            if ((r_state == RQ_IDLE) && w_any) begin
                r_vaddr    <= w_gnt_vaddr;
                r_grant_id <= w_gnt;
            end
            if ((r_state == RQ_ISSUE) && m_req_ready_i) r_timer <= '0;
            else if (r_state == RQ_WAIT)                r_timer <= r_timer + 32'd1;
            if (w_resp_hit)  r_resp_data <= m_resp_data_i;
            else if (w_fire) r_resp_data <= '0;
            // A late response drained in the same cycle a new timeout fires nets to no change.
            if (w_fire && !w_stale_drop) begin
                if (r_stale_cnt != 4'hF) r_stale_cnt <= r_stale_cnt + 4'd1;
            end else if (w_stale_drop && !w_fire) begin
                r_stale_cnt <= r_stale_cnt - 4'd1;
            end
            if (w_deliver_done) r_last_grant <= r_grant_id;
        end
    end

    assign m_req_vaddr_o = r_vaddr;
    assign s_resp_data_o = r_resp_data;
    assign grant_id_o    = r_grant_id;
    assign busy_o        = (r_state != RQ_IDLE);
    assign timeout_o     = r_timeout;

endmodule
